// File: rtl/mm_tile_controller.sv
// mm_tile_controller
//   Tiling controller for a DIM x DIM systolic matrix-multiply array.
//   Walks (m x k)*(k x n) as row-batch x column-batch tiles (column batch
//   fastest), issues A/B operand reads, drives the PE/setup strobes and
//   schedules the P result writes of every tile, including masked partial
//   edge tiles.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i                  level start request
//   valid_o / busy_o         job complete (held until start_i falls) / in progress
//   m_i, k_i, n_i            matrix dimensions, stable while busy
//   base_addr{a,b,p}_i       buffer base addresses
//   pe_clr_o, pe_we_o        first / last real operand of a tile (registered)
//   ensys_o, bubble_o        systolic setup enable / zero operand (registered)
//   ena_o, enb_o, addra_o, addrb_o   operand reads
//   wea_o, web_o             tied to 0
//   enp_o, wep_o, addrp_o    result write
//   wordp_sel_o, datap_we_o  array output column and per-row write mask
module mm_tile_controller #(
  parameter int ADDR_WIDTH = 16,
  parameter int DIM        = 8,
  parameter int OUTPUT_LAT = 2,
  localparam int SEL_W     = $clog2(DIM)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic                  valid_o,
  output logic                  busy_o,
  input  logic [ADDR_WIDTH-1:0] m_i,
  input  logic [ADDR_WIDTH-1:0] k_i,
  input  logic [ADDR_WIDTH-1:0] n_i,
  input  logic [ADDR_WIDTH-1:0] base_addra_i,
  input  logic [ADDR_WIDTH-1:0] base_addrb_i,
  input  logic [ADDR_WIDTH-1:0] base_addrp_i,
  output logic                  pe_clr_o,
  output logic                  pe_we_o,
  output logic                  ensys_o,
  output logic                  bubble_o,
  output logic                  ena_o,
  output logic                  enb_o,
  output logic [ADDR_WIDTH-1:0] addra_o,
  output logic [ADDR_WIDTH-1:0] addrb_o,
  output logic                  wea_o,
  output logic                  web_o,
  output logic                  enp_o,
  output logic                  wep_o,
  output logic [ADDR_WIDTH-1:0] addrp_o,
  output logic [SEL_W-1:0]      wordp_sel_o,
  output logic [DIM-1:0]        datap_we_o
);

  localparam int SR_LEN = DIM + OUTPUT_LAT;
  localparam logic [ADDR_WIDTH-1:0] DIM_A = ADDR_WIDTH'(DIM);
  localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);
  localparam logic [SEL_W-1:0]      ONE_S = SEL_W'(1);

  typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} main_state_e;
  typedef enum logic [1:0] {R_IDLE, R_BUSY, R_DONE} rd_state_e;
  typedef enum logic       {W_IDLE, W_WRITE}        wr_state_e;

  main_state_e main_state_q, main_state_d;
  rd_state_e   rd_state_q, rd_state_d;
  wr_state_e   wr_state_q, wr_state_d;

  // read walk: cycle in tile, tile indices, running r*k and col*k offsets
  logic [ADDR_WIDTH-1:0] cyc_q, cyc_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d;
  logic [ADDR_WIDTH-1:0] col_q, col_d;
  logic [ADDR_WIDTH-1:0] a_off_q, a_off_d;
  logic [ADDR_WIDTH-1:0] b_off_q, b_off_d;

  logic pe_clr_q, pe_clr_d;
  logic pe_we_q, pe_we_d;
  logic ensys_q, ensys_d;
  logic bubble_q, bubble_d;

  // pending-tile pipeline with each tile's edge attributes
  logic [SR_LEN-1:0] sr_we_q, sr_we_d;
  logic [SR_LEN-1:0] sr_lr_q, sr_lr_d;
  logic [SR_LEN-1:0] sr_lc_q, sr_lc_d;

  logic [SEL_W-1:0]      wsel_q, wsel_d;
  logic [SEL_W-1:0]      wlast_q, wlast_d;
  logic [DIM-1:0]        wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
  logic                  pend_q, pend_d;
  logic                  pend_lr_q, pend_lr_d;
  logic                  pend_lc_q, pend_lc_d;

  // ---------------------------------------------------------------- job geometry
  logic                  zero_dim;
  logic [ADDR_WIDTH-1:0] row_tiles, col_tiles, tile_last_c;
  logic [SEL_W-1:0]      m_rem, n_rem;

  always_comb begin
    zero_dim    = (m_i == '0) || (k_i == '0) || (n_i == '0);
    m_rem       = m_i[SEL_W-1:0];
    n_rem       = n_i[SEL_W-1:0];
    // ceil division without forming m+DIM-1, which could wrap
    row_tiles   = (m_i >> SEL_W) + ADDR_WIDTH'(|m_rem);
    col_tiles   = (n_i >> SEL_W) + ADDR_WIDTH'(|n_rem);
    tile_last_c = (k_i > DIM_A) ? (k_i - ONE_A) : (DIM_A - ONE_A);
  end

  function automatic logic [SEL_W-1:0] sel_last(input logic lc, input logic [SEL_W-1:0] rem);
    return (lc && rem != '0) ? (rem - ONE_S) : '1;
  endfunction

  function automatic logic [DIM-1:0] row_mask(input logic lr, input logic [SEL_W-1:0] rem);
    logic [DIM-1:0] mask;
    for (int unsigned i = 0; i < DIM; i++) begin
      mask[i] = !lr || (rem == '0) || (SEL_W'(i) < rem);
    end
    return mask;
  endfunction

  // ---------------------------------------------------------------- state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_state_q <= M_IDLE;
      rd_state_q   <= R_IDLE;
      wr_state_q   <= W_IDLE;
      cyc_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      a_off_q      <= '0;
      b_off_q      <= '0;
      pe_clr_q     <= 1'b0;
      pe_we_q      <= 1'b0;
      ensys_q      <= 1'b0;
      bubble_q     <= 1'b0;
      sr_we_q      <= '0;
      sr_lr_q      <= '0;
      sr_lc_q      <= '0;
      wsel_q       <= '0;
      wlast_q      <= '0;
      wmask_q      <= '0;
      wcnt_q       <= '0;
      pend_q       <= 1'b0;
      pend_lr_q    <= 1'b0;
      pend_lc_q    <= 1'b0;
    end else begin
      main_state_q <= main_state_d;
      rd_state_q   <= rd_state_d;
      wr_state_q   <= wr_state_d;
      cyc_q        <= cyc_d;
      row_q        <= row_d;
      col_q        <= col_d;
      a_off_q      <= a_off_d;
      b_off_q      <= b_off_d;
      pe_clr_q     <= pe_clr_d;
      pe_we_q      <= pe_we_d;
      ensys_q      <= ensys_d;
      bubble_q     <= bubble_d;
      sr_we_q      <= sr_we_d;
      sr_lr_q      <= sr_lr_d;
      sr_lc_q      <= sr_lc_d;
      wsel_q       <= wsel_d;
      wlast_q      <= wlast_d;
      wmask_q      <= wmask_d;
      wcnt_q       <= wcnt_d;
      pend_q       <= pend_d;
      pend_lr_q    <= pend_lr_d;
      pend_lc_q    <= pend_lc_d;
    end
  end

  // ---------------------------------------------------------------- next-state logic
  logic rd_active, in_k, last_cyc, last_row, last_col;
  logic wr_busy, word_end, wr_free;
  logic req, req_lr, req_lc;

  always_comb begin
    rd_active = (rd_state_q == R_BUSY);
    in_k      = (cyc_q < k_i);
    last_cyc  = (cyc_q == tile_last_c);
    last_row  = (row_q == row_tiles - ONE_A);
    last_col  = (col_q == col_tiles - ONE_A);
    wr_busy   = (wr_state_q == W_WRITE);
    word_end  = wr_busy && (wsel_q == wlast_q);
    wr_free   = !wr_busy || word_end;
    req       = sr_we_q[SR_LEN-1];
    req_lr    = sr_lr_q[SR_LEN-1];
    req_lc    = sr_lc_q[SR_LEN-1];
  end

  always_comb begin
    main_state_d = main_state_q;
    unique case (main_state_q)
      M_IDLE: if (start_i) main_state_d = M_BUSY;
      M_BUSY: begin
        if (zero_dim ||
            (rd_state_q == R_DONE && sr_we_q == '0 && !pend_q && !wr_busy)) begin
          main_state_d = M_DONE;
        end
      end
      M_DONE: if (!start_i) main_state_d = M_IDLE;
      default: main_state_d = M_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    cyc_d      = cyc_q;
    row_d      = row_q;
    col_d      = col_q;
    a_off_d    = a_off_q;
    b_off_d    = b_off_q;
    unique case (rd_state_q)
      R_IDLE: begin
        if (main_state_q == M_BUSY && !zero_dim) begin
          rd_state_d = R_BUSY;
          cyc_d      = '0;
          row_d      = '0;
          col_d      = '0;
          a_off_d    = '0;
          b_off_d    = '0;
        end
      end
      R_BUSY: begin
        if (!last_cyc) begin
          cyc_d = cyc_q + ONE_A;
        end else begin
          cyc_d = '0;
          if (!last_col) begin
            col_d   = col_q + ONE_A;
            b_off_d = b_off_q + k_i;
          end else begin
            col_d   = '0;
            b_off_d = '0;
            if (last_row) begin
              rd_state_d = R_DONE;
            end else begin
              row_d   = row_q + ONE_A;
              a_off_d = a_off_q + k_i;
            end
          end
        end
      end
      R_DONE: if (main_state_q == M_DONE) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Strobes are computed from the read cycle and registered; the write
  // pipeline taps the unregistered pe_we so that the registered write
  // state lands exactly DIM+OUTPUT_LAT cycles after pe_we_o.
  always_comb begin
    ensys_d  = rd_active;
    bubble_d = rd_active && !in_k;
    pe_clr_d = rd_active && (cyc_q == '0);
    pe_we_d  = rd_active && (cyc_q == k_i - ONE_A);
    sr_we_d  = {sr_we_q[SR_LEN-2:0], pe_we_d};
    sr_lr_d  = {sr_lr_q[SR_LEN-2:0], pe_we_d && last_row};
    sr_lc_d  = {sr_lc_q[SR_LEN-2:0], pe_we_d && last_col};
  end

  // A tile that arrives while another is still mid-write is parked in a
  // one-deep pending slot and launched back-to-back at the end word.
  always_comb begin
    wr_state_d = wr_state_q;
    wsel_d     = wsel_q;
    wlast_d    = wlast_q;
    wmask_d    = wmask_q;
    wcnt_d     = wcnt_q;
    pend_d     = pend_q;
    pend_lr_d  = pend_lr_q;
    pend_lc_d  = pend_lc_q;

    if (wr_busy) begin
      wcnt_d = wcnt_q + ONE_A;
      wsel_d = wsel_q + ONE_S;
    end

    if (wr_free) begin
      if (pend_q) begin
        wr_state_d = W_WRITE;
        wsel_d     = '0;
        wlast_d    = sel_last(pend_lc_q, n_rem);
        wmask_d    = row_mask(pend_lr_q, m_rem);
        pend_d     = req;
        pend_lr_d  = req_lr;
        pend_lc_d  = req_lc;
      end else if (req) begin
        wr_state_d = W_WRITE;
        wsel_d     = '0;
        wlast_d    = sel_last(req_lc, n_rem);
        wmask_d    = row_mask(req_lr, m_rem);
      end else begin
        wr_state_d = W_IDLE;
      end
    end else if (req) begin
      pend_d    = 1'b1;
      pend_lr_d = req_lr;
      pend_lc_d = req_lc;
    end

    if (main_state_q == M_IDLE) wcnt_d = '0;
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    busy_o      = (main_state_q == M_BUSY);
    valid_o     = (main_state_q == M_DONE);
    ena_o       = rd_active && in_k;
    enb_o       = rd_active && in_k;
    addra_o     = ena_o ? (base_addra_i + a_off_q + cyc_q) : '0;
    addrb_o     = enb_o ? (base_addrb_i + b_off_q + cyc_q) : '0;
    wea_o       = 1'b0;
    web_o       = 1'b0;
    pe_clr_o    = pe_clr_q;
    pe_we_o     = pe_we_q;
    ensys_o     = ensys_q;
    bubble_o    = bubble_q;
    enp_o       = wr_busy;
    wep_o       = wr_busy;
    addrp_o     = wr_busy ? (base_addrp_i + wcnt_q) : '0;
    wordp_sel_o = wr_busy ? wsel_q : '0;
    datap_we_o  = wr_busy ? wmask_q : '0;
  end

endmodule

// File: tb/tb_mm_tile_controller.sv
module tb_mm_tile_controller;

  localparam int MAXC = 512;
  localparam int LAT  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [15:0] m = '0, k = '0, n = '0, ba = '0, bb = '0, bp = '0;

  always #5 clk = ~clk;

  // DIM=8 instance outputs
  logic valid_8, busy_8, clr_8, we_8, ensys_8, bub_8, ena_8, enb_8, wea_8, web_8, enp_8, wep_8;
  logic [15:0] addra_8, addrb_8, addrp_8;
  logic [2:0]  sel_8;
  logic [7:0]  mask_8;
  // DIM=4 instance outputs
  logic valid_4, busy_4, clr_4, we_4, ensys_4, bub_4, ena_4, enb_4, wea_4, web_4, enp_4, wep_4;
  logic [15:0] addra_4, addrb_4, addrp_4;
  logic [1:0]  sel_4;
  logic [3:0]  mask_4;

  mm_tile_controller #(.ADDR_WIDTH(16), .DIM(8), .OUTPUT_LAT(LAT)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .valid_o(valid_8), .busy_o(busy_8),
    .m_i(m), .k_i(k), .n_i(n), .base_addra_i(ba), .base_addrb_i(bb), .base_addrp_i(bp),
    .pe_clr_o(clr_8), .pe_we_o(we_8), .ensys_o(ensys_8), .bubble_o(bub_8),
    .ena_o(ena_8), .enb_o(enb_8), .addra_o(addra_8), .addrb_o(addrb_8),
    .wea_o(wea_8), .web_o(web_8), .enp_o(enp_8), .wep_o(wep_8), .addrp_o(addrp_8),
    .wordp_sel_o(sel_8), .datap_we_o(mask_8));

  mm_tile_controller #(.ADDR_WIDTH(16), .DIM(4), .OUTPUT_LAT(LAT)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .valid_o(valid_4), .busy_o(busy_4),
    .m_i(m), .k_i(k), .n_i(n), .base_addra_i(ba), .base_addrb_i(bb), .base_addrp_i(bp),
    .pe_clr_o(clr_4), .pe_we_o(we_4), .ensys_o(ensys_4), .bubble_o(bub_4),
    .ena_o(ena_4), .enb_o(enb_4), .addra_o(addra_4), .addrb_o(addrb_4),
    .wea_o(wea_4), .web_o(web_4), .enp_o(enp_4), .wep_o(wep_4), .addrp_o(addrp_4),
    .wordp_sel_o(sel_4), .datap_we_o(mask_4));

  logic [63:0] obs_rd [2], obs_st [2], obs_wr [2], obs_ctl [2];
  assign obs_rd[0]  = {28'b0, ena_8, enb_8, wea_8, web_8, addra_8, addrb_8};
  assign obs_rd[1]  = {28'b0, ena_4, enb_4, wea_4, web_4, addra_4, addrb_4};
  assign obs_st[0]  = {60'b0, ensys_8, bub_8, clr_8, we_8};
  assign obs_st[1]  = {60'b0, ensys_4, bub_4, clr_4, we_4};
  assign obs_wr[0]  = {9'b0, enp_8, wep_8, addrp_8, 2'b0, sel_8, 24'b0, mask_8};
  assign obs_wr[1]  = {9'b0, enp_4, wep_4, addrp_4, 3'b0, sel_4, 28'b0, mask_4};
  assign obs_ctl[0] = {62'b0, busy_8, valid_8};
  assign obs_ctl[1] = {62'b0, busy_4, valid_4};

  logic [63:0] exp_rd [2][MAXC], exp_st [2][MAXC], exp_wr [2][MAXC], exp_ctl [2][MAXC];
  int done_at [2];
  int n_checks = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: expected per-cycle outputs of one job, cycle j counted
  // from the first clock edge that samples start=1.
  task automatic build_model(input int di, input int dim);
    int mi, ki, ni, rt, ct, t_per, wc, last_w, rd_end, j, wj0, wn, mr, nr;
    logic [15:0] a, b, p;
    logic [31:0] mask;
    mi = int'(m); ki = int'(k); ni = int'(n);
    for (int j2 = 0; j2 < MAXC; j2++) begin
      exp_rd[di][j2] = '0; exp_st[di][j2] = '0; exp_wr[di][j2] = '0; exp_ctl[di][j2] = '0;
    end
    if (mi == 0 || ki == 0 || ni == 0) begin
      done_at[di] = 2;
    end else begin
      rt = (mi + dim - 1) / dim;
      ct = (ni + dim - 1) / dim;
      t_per = (ki > dim) ? ki : dim;
      mr = mi % dim;
      nr = ni % dim;
      wc = 0;
      last_w = 0;
      for (int t = 0; t < rt * ct; t++) begin
        int r, c;
        r = t / ct;
        c = t % ct;
        for (int cy = 0; cy < t_per; cy++) begin
          j = 2 + t * t_per + cy;
          if (cy < ki) begin
            a = ba + 16'(r * ki + cy);
            b = bb + 16'(c * ki + cy);
            exp_rd[di][j] = {28'b0, 4'b1100, a, b};
          end
          exp_st[di][j + 1] = {60'b0, 1'b1, cy >= ki, cy == 0, cy == ki - 1};
        end
        wj0  = 3 + t * t_per + (ki - 1) + dim + LAT;
        wn   = (c == ct - 1 && nr != 0) ? nr : dim;
        mask = (r == rt - 1 && mr != 0) ? ((32'd1 << mr) - 1) : ((32'd1 << dim) - 1);
        for (int s = 0; s < wn; s++) begin
          p = bp + 16'(wc);
          exp_wr[di][wj0 + s] = {9'b0, 2'b11, p, 5'(s), mask};
          wc++;
        end
        last_w = wj0 + wn - 1;
      end
      rd_end = 3 + rt * ct * t_per;
      done_at[di] = (last_w + 2 > rd_end) ? last_w + 2 : rd_end;
    end
    for (int j2 = 1; j2 < MAXC; j2++)
      exp_ctl[di][j2] = (j2 < done_at[di]) ? 64'd2 : 64'd1;
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("%s d%0d rd", tag, d), obs_rd[d], '0);
      check_eq($sformatf("%s d%0d st", tag, d), obs_st[d], '0);
      check_eq($sformatf("%s d%0d wr", tag, d), obs_wr[d], '0);
      check_eq($sformatf("%s d%0d ctl", tag, d), obs_ctl[d], '0);
    end
  endtask

  // Called at #1 after an edge with the DUTs idle; stop_at>0 aborts early.
  task automatic run_job(input string name, input int stop_at);
    int last;
    build_model(0, 8);
    build_model(1, 4);
    last = ((done_at[0] > done_at[1]) ? done_at[0] : done_at[1]) + 6;
    if (stop_at > 0) last = stop_at;
    start = 1'b1;
    for (int j = 1; j <= last; j++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        check_eq($sformatf("%s d%0d j%0d rd", name, d, j), obs_rd[d], exp_rd[d][j]);
        check_eq($sformatf("%s d%0d j%0d st", name, d, j), obs_st[d], exp_st[d][j]);
        check_eq($sformatf("%s d%0d j%0d wr", name, d, j), obs_wr[d], exp_wr[d][j]);
        check_eq($sformatf("%s d%0d j%0d ctl", name, d, j), obs_ctl[d], exp_ctl[d][j]);
      end
    end
    if (stop_at == 0) begin
      start = 1'b0;
      @(posedge clk);
      #1;
      check_idle({name, " drop"});
    end
  endtask

  task automatic set_job(input int mm, input int kk, input int nn,
                         input int a, input int b, input int p);
    m = 16'(mm); k = 16'(kk); n = 16'(nn);
    ba = 16'(a); bb = 16'(b); bp = 16'(p);
  endtask

  initial begin
    #12;
    check_idle("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_idle("post_reset");

    set_job(8, 8, 8, 'h10, 'h40, 'h80);   run_job("s1", 0);
    set_job(10, 3, 12, 0, 0, 0);          run_job("s2", 0);
    set_job(4, 0, 4, 'h10, 'h20, 'h30);   run_job("s3", 0);
    set_job(5, 5, 5, 'h100, 'h200, 'h300); run_job("s5", 0);

    // reset mid-job during the second tile, then a clean rerun
    set_job(10, 3, 12, 'h11, 'h22, 'h33);
    run_job("s4a", 14);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle("s4 async");
    start = 1'b0;
    @(posedge clk);
    #1;
    check_idle("s4 held");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_job("s4b", 0);

    set_job(3, 2, 9, 'hFFFE, 'hFFFC, 'hFFFA); run_job("wrap", 0);

    for (int i = 0; i < 10; i++) begin
      int mm, kk, nn;
      mm = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
      kk = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 10));
      nn = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
      set_job(mm, kk, nn, int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
      run_job($sformatf("rnd%0d", i), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
